// File: rtl/rx_deser.sv
// -----------------------------------------------------------------------------
// rx_deser -- serial link receiver with output FIFO
//
// Purpose
//   Receives frames from the upstream serial transmitter of the same link port.
//   Each frame is a start bit (1) followed by W data bits, LSB first, one bit
//   per clock. There is no stop bit. Completed words go into a small FIFO that
//   the router core drains. channel_busy tells the transmitter not to start a
//   new frame.
//
// Ports
//   clk           in   1   single clock, all logic on posedge
//   reset         in   1   asynchronous, active-low reset
//   serial_in     in   1   link line from transmitter, idles at 0
//   channel_busy  out  1   transmitter must not start a frame while high
//   parallel_out  out  W   word at the head of the FIFO
//   out_valid     out  1   FIFO not empty
//   out_ack       in   1   pops the head when out_valid is also high
//   rx_active     out  1   a frame is being received
//   overflow      out  1   sticky: a completed frame was dropped (FIFO full)
// -----------------------------------------------------------------------------
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module rx_deser #(
  parameter int routerid = -1,
  parameter     port     = "unknown",
  parameter int DEPTH    = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 serial_in,
  output logic                                 channel_busy,
  output logic [`PAYLOAD_SIZE+`ADDR_BITS-1:0]  parallel_out,
  output logic                                 out_valid,
  input  logic                                 out_ack,
  output logic                                 rx_active,
  output logic                                 overflow
);

  localparam int W  = `PAYLOAD_SIZE + `ADDR_BITS;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  // Debug-only identity parameters; they carry no logic.
  logic unused_params;
  assign unused_params = (routerid < 0) ^ (port == "unknown");

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  bitcnt_q, bitcnt_d;
  // The last data bit is taken straight from the line when the word is
  // pushed, so only W-1 bits need storing.
  logic [W-2:0]   shreg_q, shreg_d;
  logic           last_bit;
  logic [W-1:0]   frame_word;

  assign last_bit   = (state_q == S_RECV) && (bitcnt_q == CW'(W - 1));
  assign frame_word = {serial_in, shreg_q};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Frame length is fixed: data content never ends a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (serial_in) state_d = S_RECV;
      S_RECV:  if (last_bit)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO status used by the output logic
  logic [NW-1:0] count_q;
  logic          full;
  assign full = (count_q == NW'(DEPTH));

  // Output logic. Busy is built from registered state only, so the
  // transmitter never sees a combinational path from its own line.
  always_comb begin
    rx_active    = (state_q == S_RECV);
    channel_busy = (state_q == S_RECV) | full;
  end

  // Bit counter and shift register
  always_comb begin
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (serial_in) bitcnt_d = '0;
      end
      S_RECV: begin
        for (int i = 0; i < W - 1; i++) begin
          if (bitcnt_q == CW'(i)) shreg_d[i] = serial_in;
        end
        if (!last_bit) bitcnt_d = bitcnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitcnt_q <= '0;
      shreg_q  <= '0;
    end else begin
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic          overflow_q;
  logic          pop, push_ok, drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop     = (count_q != '0) & out_ack;
  // A full FIFO still accepts the word if the head leaves on the same edge.
  assign push_ok = last_bit & (~full | pop);
  assign drop    = last_bit & full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= frame_word;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign parallel_out = mem_q[rd_q];
  assign out_valid    = (count_q != '0);
  assign overflow     = overflow_q;

endmodule
